// File: rtl/regfile_scoreboard.sv
// Integer register file with parametrised read ports, optional write-back bypass
// and a per-register pending-write scoreboard that raises STALL on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                         CLK,
    input  logic                         RES,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] A_Q,
    input  logic [NUM_RD-1:0]            RD_USE,
    output logic [NUM_RD*DATA_WIDTH-1:0] Q,
    output logic [NUM_RD-1:0]            Q_BUSY,
    input  logic [DATA_WIDTH-1:0]        D,
    input  logic [ADDR_WIDTH-1:0]        A_D,
    input  logic                         write_enable,
    input  logic                         ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0]        A_ISSUE,
    input  logic                         FLUSH,
    output logic                         STALL
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam bit          BYP_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    logic wb_valid;
    logic wb_hit_issue;
    logic issue_busy;
    logic issue_set;

    // Writes to x0 are discarded, so x0 data stays zero and it is never cleared/set busy.
    assign wb_valid     = write_enable && (A_D != '0);
    assign wb_hit_issue = wb_valid && (A_D == A_ISSUE);
    // A bypassed write-back retires the pending producer in the same cycle.
    assign issue_busy   = busy[A_ISSUE] && !(BYP_EN && wb_hit_issue);

    // Hazard detection: RAW on any used operand, WAW on the issue destination.
    assign STALL = !RES && ((|(Q_BUSY & RD_USE)) ||
                            (ISSUE_EN && (A_ISSUE != '0) && issue_busy));

    assign issue_set = ISSUE_EN && !STALL && !FLUSH && (A_ISSUE != '0);

    // Combinational read ports with optional write-back forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  fwd;

        assign addr = A_Q[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign fwd  = BYP_EN && wb_valid && (A_D == addr);

        assign Q[k*DATA_WIDTH +: DATA_WIDTH] =
            (RES || (addr == '0)) ? '0 :
            fwd                   ? D  : regs[addr];
        assign Q_BUSY[k] = !RES && (addr != '0) && !fwd && busy[addr];
    end

    // Register data: async clear, write-back at the edge (never blocked by FLUSH).
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[A_D] <= D;
        end
    end

    // Scoreboard: flush beats issue-set, which beats write-back clear.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            busy <= '0;
        end else if (FLUSH) begin
            busy <= '0;
        end else begin
            if (wb_valid) begin
                busy[A_D] <= 1'b0;
            end
            // Later assignment wins when issue and write-back hit the same register.
            if (issue_set) begin
                busy[A_ISSUE] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one BYPASS=1 and one BYPASS=0 instance
// share every input so forwarding and non-forwarding behaviour are checked side by side.
module tb_regfile_scoreboard;

    logic        CLK;
    logic        RES;
    logic [9:0]  A_Q;
    logic [1:0]  RD_USE;
    logic [31:0] D;
    logic [4:0]  A_D;
    logic        write_enable;
    logic        ISSUE_EN;
    logic [4:0]  A_ISSUE;
    logic        FLUSH;

    logic [63:0] q_b, q_n;
    logic [1:0]  qb_b, qb_n;
    logic        stall_b, stall_n;

    int n_vec;
    int n_err;

    regfile_scoreboard #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)
    ) u_byp (
        .CLK(CLK), .RES(RES), .A_Q(A_Q), .RD_USE(RD_USE), .Q(q_b), .Q_BUSY(qb_b),
        .D(D), .A_D(A_D), .write_enable(write_enable), .ISSUE_EN(ISSUE_EN),
        .A_ISSUE(A_ISSUE), .FLUSH(FLUSH), .STALL(stall_b)
    );

    regfile_scoreboard #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)
    ) u_nb (
        .CLK(CLK), .RES(RES), .A_Q(A_Q), .RD_USE(RD_USE), .Q(q_n), .Q_BUSY(qb_n),
        .D(D), .A_D(A_D), .write_enable(write_enable), .ISSUE_EN(ISSUE_EN),
        .A_ISSUE(A_ISSUE), .FLUSH(FLUSH), .STALL(stall_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        A_Q          = '0;
        RD_USE       = '0;
        D            = '0;
        A_D          = '0;
        write_enable = 1'b0;
        ISSUE_EN     = 1'b0;
        A_ISSUE      = '0;
        FLUSH        = 1'b0;
    endtask

    // Advance one rising edge, then settle just past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        RES = 1'b1;
        #2;
        check("rst_q",     q_b, 64'h0);
        check("rst_busy",  {62'h0, qb_b}, 64'h0);
        check("rst_stall", {63'h0, stall_b}, 64'h0);
        step();
        RES = 1'b0;

        // Load x5 and issue x12 in the same cycle.
        write_enable = 1'b1; A_D = 5'd5; D = 32'hDEADBEEF;
        ISSUE_EN = 1'b1; A_ISSUE = 5'd12;
        #1;
        check("ld_nostall", {63'h0, stall_b}, 64'h0);
        step();
        idle();
        A_Q = {5'd12, 5'd5};
        #1;
        check("ld_x5_byp",  q_b[31:0], 64'hDEADBEEF);
        check("ld_x5_nb",   q_n[31:0], 64'hDEADBEEF);
        check("ld_busy12",  {62'h0, qb_b}, 64'h2);

        // Mid-cycle reset: everything clears without a clock edge.
        RD_USE = 2'b11; ISSUE_EN = 1'b1; A_ISSUE = 5'd12;
        #1;
        check("pre_rst_stall", {63'h0, stall_b}, 64'h1);
        RES = 1'b1;
        #1;
        check("mid_rst_q",     q_b, 64'h0);
        check("mid_rst_busy",  {62'h0, qb_b}, 64'h0);
        check("mid_rst_stall", {63'h0, stall_b}, 64'h0);
        step();
        RES = 1'b0;
        #1;
        check("post_rst_q",     {q_n[31:0], q_b[31:0]}, 64'h0);
        check("post_rst_busy",  {60'h0, qb_n, qb_b}, 64'h0);
        check("post_rst_stall", {62'h0, stall_n, stall_b}, 64'h0);
        idle();

        // Write x7: forwarded in the same cycle only with bypass.
        step();
        write_enable = 1'b1; A_D = 5'd7; D = 32'h12345678; A_Q = {5'd0, 5'd7};
        #1;
        check("wr7_byp", q_b[31:0], 64'h12345678);
        check("wr7_nb",  q_n[31:0], 64'h0);
        step();
        idle();
        A_Q = {5'd7, 5'd7};
        #1;
        check("wr7_nb_after", q_n[31:0], 64'h12345678);
        check("dual_port7",   q_b, 64'h12345678_12345678);

        // x0 ignores writes and issues.
        write_enable = 1'b1; A_D = 5'd0; D = 32'hFFFFFFFF;
        ISSUE_EN = 1'b1; A_ISSUE = 5'd0; A_Q = '0; RD_USE = 2'b11;
        #1;
        check("x0_q_same",  q_b, 64'h0);
        check("x0_stall",   {63'h0, stall_b}, 64'h0);
        step();
        #1;
        check("x0_q_after", q_b, 64'h0);
        check("x0_busy",    {60'h0, qb_n, qb_b}, 64'h0);
        check("x0_stall2",  {62'h0, stall_n, stall_b}, 64'h0);
        idle();

        // RAW on x3.
        ISSUE_EN = 1'b1; A_ISSUE = 5'd3;
        #1;
        check("raw_issue_ok", {63'h0, stall_b}, 64'h0);
        step();
        idle();
        A_Q = {5'd3, 5'd0}; RD_USE = 2'b10;
        #1;
        check("raw_stall",   {63'h0, stall_b}, 64'h1);
        check("raw_qbusy",   {62'h0, qb_b}, 64'h2);
        RD_USE = 2'b00;
        #1;
        check("raw_unused",  {63'h0, stall_b}, 64'h0);
        RD_USE = 2'b10; write_enable = 1'b1; A_D = 5'd3; D = 32'h0000A5A5;
        #1;
        check("raw_wb_byp",  {63'h0, stall_b}, 64'h0);
        check("raw_wb_q",    q_b[63:32], 64'h0000A5A5);
        check("raw_wb_nb",   {63'h0, stall_n}, 64'h1);
        step();
        write_enable = 1'b0;
        #1;
        check("raw_clr",     {60'h0, qb_n, qb_b}, 64'h0);
        check("raw_clr_st",  {62'h0, stall_n, stall_b}, 64'h0);
        check("raw_nb_q",    q_n[63:32], 64'h0000A5A5);
        idle();

        // WAW on x9, then issue/write-back collision.
        ISSUE_EN = 1'b1; A_ISSUE = 5'd9;
        step();
        A_Q = {5'd0, 5'd9};
        #1;
        check("waw_stall",   {63'h0, stall_b}, 64'h1);
        step();
        #1;
        check("waw_busy",    {62'h0, qb_b}, 64'h1);
        write_enable = 1'b1; A_D = 5'd9; D = 32'h00000099;
        #1;
        check("col_byp_st",  {63'h0, stall_b}, 64'h0);
        check("col_nb_st",   {63'h0, stall_n}, 64'h1);
        step();
        idle();
        A_Q = {5'd0, 5'd9};
        #1;
        check("col_byp_busy", {62'h0, qb_b}, 64'h1);
        check("col_byp_q",    q_b[31:0], 64'h99);
        check("col_nb_busy",  {62'h0, qb_n}, 64'h0);
        check("col_nb_q",     q_n[31:0], 64'h99);
        write_enable = 1'b1; A_D = 5'd9; D = 32'h00000099;
        step();
        idle();

        // Flush with concurrent issue and write-back.
        ISSUE_EN = 1'b1; A_ISSUE = 5'd4;
        step();
        A_ISSUE = 5'd6;
        step();
        idle();
        A_Q = {5'd6, 5'd4};
        #1;
        check("fl_pre_busy", {60'h0, qb_n, qb_b}, 64'hF);
        FLUSH = 1'b1; ISSUE_EN = 1'b1; A_ISSUE = 5'd8;
        write_enable = 1'b1; A_D = 5'd4; D = 32'h00004444;
        #1;
        check("fl_nostall",  {63'h0, stall_b}, 64'h0);
        step();
        idle();
        A_Q = {5'd6, 5'd4};
        #1;
        check("fl_busy",     {60'h0, qb_n, qb_b}, 64'h0);
        check("fl_q4",       {q_n[31:0], q_b[31:0]}, 64'h00004444_00004444);
        A_Q = {5'd0, 5'd8};
        #1;
        check("fl_busy8",    {60'h0, qb_n, qb_b}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Generalised read-port count and optional write-back bypass.
- Adds a per-register pending-write scoreboard: the decode stage marks a destination busy at issue, and write-back clears it.
- Generates a hazard STALL for the pipeline controller. Sits between decode (read/issue) and write-back in the RISC-V pipeline.

Parameters:
DATA_WIDTH, 32, register width
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
NUM_RD, 2, number of asynchronous read ports (1..4)
BYPASS, 1, 1 = write-back data/busy-clear visible to reads in the same cycle; 0 = visible after the clock edge

Ports:
CLK  in  1  clock, all state updates on rising edge
RES  in  1  reset, asynchronous, active-high; clears all registers and busy bits
A_Q  in  NUM_RD*ADDR_WIDTH  read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
RD_USE  in  NUM_RD  port k operand actually needed this cycle
Q  out  NUM_RD*DATA_WIDTH  read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
Q_BUSY  out  NUM_RD  port k addresses a register with an outstanding write
D  in  DATA_WIDTH  write-back data
A_D  in  ADDR_WIDTH  write-back address
write_enable  in  1  write-back strobe
ISSUE_EN  in  1  decode issues an instruction writing A_ISSUE
A_ISSUE  in  ADDR_WIDTH  destination of issuing instruction
FLUSH  in  1  pipeline flush: clear all busy bits
STALL  out  1  hazard: decode must hold

Behaviour:
- State: regs[0..2**ADDR_WIDTH-1] (DATA_WIDTH each) and busy[0..2**ADDR_WIDTH-1].
- RES high, at any time including mid-operation: all regs = 0, all busy = 0, immediately and without a clock. While RES is high, Q = 0, Q_BUSY = 0 and STALL = 0 (ISSUE_EN ignored).
- Register 0: reads always 0 and never busy. Writes and issues to 0 are ignored.
- Write-back: if write_enable && A_D != 0, then at the rising edge regs[A_D] <= D and busy[A_D] <= 0.
- wb_hit(a) = write_enable && A_D == a && a != 0.
- Read port k, combinational:
  - If BYPASS=1 && wb_hit(A_Q[k]): Q[k] = D and Q_BUSY[k] = 0.
  - Otherwise: Q[k] = regs[A_Q[k]] and Q_BUSY[k] = busy[A_Q[k]].
- Effective busy of the issue destination:
  - ib = busy[A_ISSUE] && !(BYPASS && wb_hit(A_ISSUE)).
  - This is the WAW check: a second producer to a pending register stalls.
- STALL = !RES && ( |(Q_BUSY & RD_USE) || (ISSUE_EN && A_ISSUE != 0 && ib) ). Combinational, no latency.
- Issue: if ISSUE_EN && !STALL && !FLUSH && A_ISSUE != 0, then busy[A_ISSUE] <= 1 at the edge.
- Same-edge priority on a busy bit, highest first:
  1. FLUSH clears every bit.
  2. Issue set.
  3. Write-back clear.
- Consequence: issue and write-back to the same register in the same cycle with BYPASS=1 leaves busy = 1 (new producer). The register data is still written.
- FLUSH never blocks the data write; only busy bits are affected.
- Multiple read ports may address the same register; all return identical data and busy.
- No internal pipelining: read latency 0, write/busy update latency 1 edge.

Test Plan:
- Reset: load x5=0xDEADBEEF, assert RES mid-cycle (no edge) → Q for A_Q=5 reads 0 immediately, STALL=0. After release, busy all 0.
- Write/read, BYPASS=1: write_enable=1, A_D=7, D=0x12345678, A_Q port0=7 → Q0=0x12345678 in the same cycle. BYPASS=0 build: Q0 shows old 0 until after the edge.
- x0: write D=0xFFFFFFFF to A_D=0, issue A_ISSUE=0 → Q=0, Q_BUSY=0, STALL never asserts.
- RAW stall: issue A_ISSUE=3; next cycle A_Q port1=3 with RD_USE[1]=1 → STALL=1, Q_BUSY[1]=1. With RD_USE[1]=0 → STALL=0. Write-back A_D=3 (BYPASS=1) → STALL drops that cycle.
- WAW + collision: issue 9, then issue 9 again → STALL=1 and busy unchanged. Issue 9 in the same cycle as write-back to 9 (BYPASS=1) → no stall, busy[9]=1 after the edge, regs[9]=D.
- Flush: busy on x4, x6; FLUSH=1 with ISSUE_EN=1, A_ISSUE=8, write-back to x4 → after the edge all busy = 0 (x8 not set), regs[4] updated.
